// File: rtl/debounced_pio_in_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
// The master side drives address/strobes, the slave returns readdata.
interface debounced_pio_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/debounced_pio_in.sv
// Debounced input PIO: per-bit synchroniser, debounce filter with bypass,
// rise/fall edge capture and a maskable level interrupt.
module debounced_pio_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    debounced_pio_in_if.slave  bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_RAW   = 3'd1;
    localparam logic [2:0] A_MASK  = 3'd2;
    localparam logic [2:0] A_EDGE  = 3'd3;
    localparam logic [2:0] A_RISE  = 3'd4;
    localparam logic [2:0] A_FALL  = 3'd5;
    localparam logic [2:0] A_DBEN  = 3'd6;
    localparam logic [2:0] A_NONE  = 3'd7;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] deb_en;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      rd_mux;

    assign wr    = bus.chipselect && !bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    assign sync  = sync_q[SYNC_STAGES-1];

    generate
        if (WIDTH < 32) begin : g_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Bypassed bits track sync directly and keep their counter parked at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!deb_en[i]) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise = stable & ~prev & rise_en;
    assign fall = ~stable & prev & fall_en;
    assign w1c  = (wr && bus.address == A_EDGE) ? wdata : '0;

    // A new edge overrides a simultaneous clear so no event is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev   <= '0;
            edge_q <= '0;
        end else begin
            prev   <= stable;
            edge_q <= (edge_q & ~w1c) | rise | fall;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            deb_en   <= '1;
        end else if (wr) begin
            unique case (bus.address)
                A_MASK:  irq_mask <= wdata;
                A_RISE:  rise_en  <= wdata;
                A_FALL:  fall_en  <= wdata;
                A_DBEN:  deb_en   <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            A_DATA: rd_mux = 32'(stable);
            A_RAW:  rd_mux = 32'(sync);
            A_MASK: rd_mux = 32'(irq_mask);
            A_EDGE: rd_mux = 32'(edge_q);
            A_RISE: rd_mux = 32'(rise_en);
            A_FALL: rd_mux = 32'(fall_en);
            A_DBEN: rd_mux = 32'(deb_en);
            A_NONE: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edge_q & irq_mask);

endmodule

// File: tb/tb_debounced_pio_in.sv
// Randomised and directed bench for debounced_pio_in with a
// behavioural window-based reference model.
module tb_debounced_pio_in;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_port;
    logic       irq;

    always #5 clk = ~clk;

    debounced_pio_in_if bus();

    debounced_pio_in #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .in_port(in_port),
        .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  in_hist[$];
    logic [7:0]  sync_hist[$];
    logic [7:0]  m_sync, m_stable, m_prev, m_edge;
    logic [7:0]  m_mask, m_rise, m_fall, m_den;
    logic [31:0] m_rd;

    function automatic logic m_irq();
        return |(m_edge & m_mask);
    endfunction

    task automatic model_reset();
        in_hist.delete();
        sync_hist.delete();
        m_sync   = '0;
        m_stable = '0;
        m_prev   = '0;
        m_edge   = '0;
        m_mask   = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_den    = 8'hFF;
        m_rd     = '0;
    endtask

    // One clock: drive inputs, take the edge, advance the model.
    task automatic tick(input logic [7:0] x, input logic cs,
                        input logic wn, input logic [2:0] a,
                        input logic [31:0] wd);
        logic [7:0] nst, w1c, wv, ned;
        logic       ok;
        in_port        = x;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        @(posedge clk);
        case (a)
            3'd0:    m_rd = {24'b0, m_stable};
            3'd1:    m_rd = {24'b0, m_sync};
            3'd2:    m_rd = {24'b0, m_mask};
            3'd3:    m_rd = {24'b0, m_edge};
            3'd4:    m_rd = {24'b0, m_rise};
            3'd5:    m_rd = {24'b0, m_fall};
            3'd6:    m_rd = {24'b0, m_den};
            default: m_rd = '0;
        endcase
        wv  = wd[7:0];
        w1c = (cs && !wn && a == 3'd3) ? wv : 8'h00;
        sync_hist.push_back(m_sync);
        if (sync_hist.size() > 16) void'(sync_hist.pop_front());
        for (int i = 0; i < 8; i++) begin
            if (!m_den[i]) begin
                nst[i] = m_sync[i];
            end else begin
                // accept only after D consecutive samples differ from stable
                ok = (sync_hist.size() >= D);
                for (int j = 0; j < D && ok; j++) begin
                    if (sync_hist[sync_hist.size()-1-j][i] == m_stable[i])
                        ok = 1'b0;
                end
                nst[i] = ok ? ~m_stable[i] : m_stable[i];
            end
        end
        ned = (m_edge & ~w1c)
            | (m_stable & ~m_prev & m_rise)
            | (~m_stable & m_prev & m_fall);
        m_prev   = m_stable;
        m_stable = nst;
        m_edge   = ned;
        if (cs && !wn) begin
            case (a)
                3'd2: m_mask = wv;
                3'd4: m_rise = wv;
                3'd5: m_fall = wv;
                3'd6: m_den  = wv;
                default: ;
            endcase
        end
        in_hist.push_back(x);
        if (in_hist.size() > 16) void'(in_hist.pop_front());
        m_sync = (in_hist.size() >= 2) ? in_hist[in_hist.size()-2] : 8'h00;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        for (int a = 0; a < 8; a++) begin
            tick(8'h00, 1'b0, 1'b1, 3'(a), 32'h0);
            exp = (a == 6) ? 32'h0000_00FF : 32'h0;
            checks++;
            if (bus.readdata !== exp) begin
                errors++;
                $display("FAIL reset_read a=%0d got=%h exp=%h", a, bus.readdata, exp);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] exp;
        tick(8'h00, 1'b1, 1'b0, 3'd4, 32'h1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) begin
                tick((k < 3) ? 8'h01 : 8'h00, 1'b0, 1'b1, 3'd0, 32'h0);
                checks++;
                if (bus.readdata !== 32'h0 || m_rd !== 32'h0) begin
                    errors++;
                    $display("FAIL bounce_data got=%h model=%h exp=0", bus.readdata, m_rd);
                end
            end
        end
        repeat (4) tick(8'h00, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL bounce_edge got=%h exp=0", bus.readdata);
        end
        for (int i = 1; i <= 9; i++) begin
            tick(8'h01, 1'b0, 1'b1, 3'd0, 32'h0);
            exp = (i >= 7) ? 32'h1 : 32'h0;
            checks++;
            if (bus.readdata !== exp || m_rd !== exp) begin
                errors++;
                $display("FAIL hold_data i=%0d got=%h model=%h exp=%h",
                         i, bus.readdata, m_rd, exp);
            end
        end
        tick(8'h01, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata !== 32'h1) begin
            errors++;
            $display("FAIL hold_edge got=%h exp=1", bus.readdata);
        end
    endtask

    task automatic test_fall();
        tick(8'h01, 1'b1, 1'b0, 3'd4, 32'h0);
        tick(8'h01, 1'b1, 1'b0, 3'd5, 32'h2);
        tick(8'h01, 1'b1, 1'b0, 3'd3, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            tick(8'h03, 1'b0, 1'b1, 3'd3, 32'h0);
            checks++;
            if (bus.readdata !== m_rd || bus.readdata !== 32'h0) begin
                errors++;
                $display("FAIL fall_rise_edge got=%h model=%h exp=0", bus.readdata, m_rd);
            end
        end
        for (int i = 0; i < 10; i++) tick(8'h01, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata !== 32'h2) begin
            errors++;
            $display("FAIL fall_edge got=%h exp=2", bus.readdata);
        end
    endtask

    task automatic test_irq();
        tick(8'h01, 1'b1, 1'b0, 3'd5, 32'h3);
        for (int i = 0; i < 8; i++) tick(8'h00, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata !== 32'h3) begin
            errors++;
            $display("FAIL irq_edge_setup got=%h exp=3", bus.readdata);
        end
        tick(8'h00, 1'b1, 1'b0, 3'd2, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_mask0 got=%b exp=1", irq);
        end
        tick(8'h00, 1'b1, 1'b0, 3'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c got=%b exp=0", irq);
        end
        tick(8'h00, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata !== 32'h2) begin
            errors++;
            $display("FAIL w1c_edge got=%h exp=2", bus.readdata);
        end
        tick(8'h00, 1'b1, 1'b0, 3'd2, 32'h2);
        checks++;
        if (irq !== 1'b1 || m_irq() !== 1'b1) begin
            errors++;
            $display("FAIL irq_mask1 got=%b exp=1", irq);
        end
    endtask

    task automatic test_w1c_collision();
        tick(8'h00, 1'b1, 1'b0, 3'd5, 32'h0);
        tick(8'h00, 1'b1, 1'b0, 3'd4, 32'h1);
        tick(8'h00, 1'b1, 1'b0, 3'd3, 32'hFF);
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) tick(8'h01, 1'b1, 1'b0, 3'd3, 32'h1);
            else        tick(8'h01, 1'b0, 1'b1, 3'd0, 32'h0);
        end
        tick(8'h01, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata[0] !== 1'b1 || bus.readdata !== m_rd) begin
            errors++;
            $display("FAIL w1c_collision got=%h model=%h exp_bit0=1", bus.readdata, m_rd);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        tick(8'h00, 1'b1, 1'b0, 3'd6, 32'hFE);
        repeat (8) tick(8'h00, 1'b0, 1'b1, 3'd0, 32'h0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 6; i++) begin
                tick((i == 1) ? 8'h01 : 8'h00, 1'b0, 1'b1, 3'(1 - p), 32'h0);
                exp = (i == 3 + p) ? 32'h1 : 32'h0;
                checks++;
                if (bus.readdata !== exp || m_rd !== exp) begin
                    errors++;
                    $display("FAIL bypass_%s i=%0d got=%h model=%h exp=%h",
                             (p == 0) ? "raw" : "data", i, bus.readdata, m_rd, exp);
                end
            end
        end
        repeat (3) tick(8'h02, 1'b0, 1'b1, 3'd0, 32'h0);
        reset_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if (bus.readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rd=%h irq=%b exp=0/0", bus.readdata, irq);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            tick(8'h02, 1'b0, 1'b1, 3'(a), 32'h0);
            exp = (a == 6) ? 32'hFF : 32'h0;
            checks++;
            if (bus.readdata !== exp || m_rd !== exp) begin
                errors++;
                $display("FAIL post_reset a=%0d got=%h exp=%h", a, bus.readdata, exp);
            end
        end
        tick(8'h02, 1'b0, 1'b1, 3'd0, 32'h0);
        checks++;
        if (bus.readdata !== 32'h2) begin
            errors++;
            $display("FAIL redebounce got=%h exp=2", bus.readdata);
        end
        tick(8'h02, 1'b0, 1'b1, 3'd3, 32'h0);
        checks++;
        if (bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL no_edge_after_reset got=%h exp=0", bus.readdata);
        end
    endtask

    task automatic test_random();
        logic [7:0]  x;
        logic [31:0] wd;
        logic [2:0]  a;
        logic        wr;
        x = 8'h00;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) x[b] = ~x[b];
            end
            wr = ($urandom_range(0, 9) < 2);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            tick(x, wr, !wr, a, wd);
            checks++;
            if (bus.readdata !== m_rd) begin
                errors++;
                $display("FAIL rand_read n=%0d a=%0d got=%h exp=%h", n, a, bus.readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq()) begin
                errors++;
                $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_irq());
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 8'h00;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        model_reset();
        #12;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_debounce();
        test_fall();
        test_irq();
        test_w1c_collision();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
